// File: rtl/err_compute_seq.sv
// err_compute_seq: sequential line-follower error engine (weighted R minus L IR sum, saturated)
// Ports:
//   clk            system clock, all state on posedge
//   rst_n          synchronous active-low reset
//   strt           start request, sampled in IDLE and DONE
//   IR_R / IR_L    packed right/left IR readings, channel i at [i*IR_W +: IR_W]
//   busy           high while a conversion is in flight (includes the DONE cycle)
//   err_vld        one-cycle strobe when error is updated
//   error          saturated signed error, held between conversions
module err_compute_seq #(
  parameter int NUM_PAIRS = 4,
  parameter int IR_W      = 12,
  parameter int ERR_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          strt,
  input  logic [NUM_PAIRS*IR_W-1:0]     IR_R,
  input  logic [NUM_PAIRS*IR_W-1:0]     IR_L,
  output logic                          busy,
  output logic                          err_vld,
  output logic signed [ERR_W-1:0]       error
);
  localparam int NT    = 2*NUM_PAIRS;
  localparam int CW    = $clog2(NT);
  localparam int ACC_W = IR_W+NUM_PAIRS+1;
  localparam int WW    = ACC_W+ERR_W;
  localparam logic signed [WW-1:0] HI = WW'((64'sd1 <<< (ERR_W-1)) - 64'sd1);
  localparam logic signed [WW-1:0] LO = WW'(-(64'sd1 <<< (ERR_W-1)));
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t                      state_q;
  logic [CW-1:0]               cnt_q;
  logic signed [ACC_W-1:0]     acc_q, acc_d, term;
  logic [NUM_PAIRS*IR_W-1:0]   snap_r_q, snap_l_q, sel_w;
  logic [IR_W-1:0]             rd;
  logic signed [WW-1:0]        acc_x;
  logic signed [ERR_W-1:0]     error_q, err_d;
  logic                        err_vld_q;
  int                          ch;
  // Even count steps add the right channel, odd steps subtract the left one.
  always_comb begin
    ch    = int'(cnt_q >> 1);
    sel_w = cnt_q[0] ? snap_l_q : snap_r_q;
    rd    = sel_w[ch*IR_W +: IR_W];
    term  = ACC_W'(rd) << ch;
    acc_d = cnt_q[0] ? acc_q - term : acc_q + term;
    acc_x = WW'(acc_q);
    err_d = acc_x > HI ? ERR_W'(HI) : acc_x < LO ? ERR_W'(LO) : ERR_W'(acc_x);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      error_q   <= '0;
      err_vld_q <= 1'b0;
      snap_r_q  <= '0;
      snap_l_q  <= '0;
    end else begin
      err_vld_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            error_q   <= err_d;
            err_vld_q <= 1'b1;
          end
          if (strt) begin
            snap_r_q <= IR_R;
            snap_l_q <= IR_L;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ACCUM;
          end else begin
            state_q  <= IDLE;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NT-1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy    = state_q != IDLE;
  assign err_vld = err_vld_q;
  assign error   = error_q;
endmodule
